io_wr_regs: RTL
===============

# io_wr_regs

Write-side counterpart of the core I/O read multiplexer. Owns the core-internal I/O registers (SPL, SPH, SREG, optional RAMPZ), accepts I/O-bus writes at their addresses, and applies stack-pointer push/pop steps plus SREG flag updates from the execution pipeline. Its outputs `spl_out`, `sph_out`, `sreg_out` and `rampz_out` feed the read mux and the rest of the core.

## Interface
- `SP_RESET`, default 16'h08FF: stack pointer value after reset (RAMEND).
- `SP_BITS`, default 12: implemented SP bits. Bits at or above `SP_BITS` are stored and read as 0.
- `cp2`  in  1: core clock. All state updates on its rising edge.
- `ireset`  in  1: reset. Synchronous and active-high.
- `adr`  in  6: I/O address.
- `iowe`  in  1: I/O write strobe.
- `dbusout`  in  8: I/O write data.
- `sp_inc`  in  1: pop request. SP increases by the step.
- `sp_dec`  in  1: push request. SP decreases by the step.
- `sp_step2`  in  1: step is 2 (return address) when 1, and 1 when 0.
- `sreg_fl_in`  in  8: new flag values from the ALU.
- `sreg_fl_we`  in  8: per-bit write mask for `sreg_fl_in`.
- `bset`, `bclr`  in  1: set or clear the single SREG bit selected by `sreg_bit`.
- `sreg_bit`  in  3: bit index used by `bset`/`bclr`.
- `irq_ack`  in  1: interrupt entry. Clears I (bit 7).
- `reti`  in  1: return from interrupt. Sets I.
- `spl_out`, `sph_out`, `sreg_out`, `rampz_out`  out  8: register contents.
- `sp_wr_busy`  out  1: interrupt-inhibit flag raised by an SP I/O write.

## Operation
- Addresses: SPL 6'h3D, SPH 6'h3E, SREG 6'h3F, RAMPZ 6'h3B. Writes to any other address are ignored.
- Reset values: SP = `SP_RESET` masked to `SP_BITS`, so `spl_out`=8'hFF and `sph_out`=8'h08. `sreg_out`=0, `rampz_out`=0, `sp_wr_busy`=0.
- SP priority per cycle:
  1. An I/O write to SPL or SPH updates that byte only. Any `sp_inc`/`sp_dec` in the same cycle is discarded.
  2. Otherwise `sp_inc` and `sp_dec` together leave SP unchanged (protocol error, no update).
  3. Otherwise a single step applies, modulo 2^`SP_BITS`. For example, a pop from 12'hFFF wraps to 0, and a push from 0 with step 2 gives 12'hFFE.
- SREG update order within one cycle, each stage overriding the previous:
  1. ALU masked write: `sreg = (sreg & ~we) | (fl_in & we)`.
  2. `bset`/`bclr`. `bset` wins if both are asserted.
  3. `reti` sets I.
  4. `irq_ack` clears I. It beats `reti`.
  5. An I/O write to SREG replaces all 8 bits and beats every stage above.
- `sp_wr_busy`:
  - Set for exactly the one cycle following any I/O write to SPL or SPH.
  - Back-to-back writes (SPL, then SPH) keep it high through the cycle after the last write.
  - The interrupt controller must not take `irq_ack` while it is high, so the two SP halves load atomically.
- Reset wins over every input in the same cycle. A reset asserted mid-push/pop returns all state to reset values on that edge.

## Timing
- Every write and step takes effect at the `cp2` edge that samples it. The new value is visible on outputs in the next cycle, with no combinational path from inputs to outputs.
- `sp_wr_busy` is registered and high in cycle N+1 for a write sampled in cycle N.
- Throughput is one operation per cycle, with no stalls.

## Configuration
- `CORE_RAMPZ_EN` defined:
  - RAMPZ register at 6'h3B.
  - Reset value 0; all 8 bits writable via I/O.
  - `rampz_out` reflects it.
- Not defined:
  - No RAMPZ storage; writes to 6'h3B are ignored.
  - `rampz_out` is tied to 8'h00.

## Structure
- Shared package `core_io_pkg`:
  - Address localparams `P_SPL_ADDRESS`, `P_SPH_ADDRESS`, `P_SREG_ADDRESS`, `P_RAMPZ_ADDRESS`.
  - SREG bit index constants (`SREG_I`=7 … `SREG_C`=0).
  - These are also used by the read mux.
- Sub-module `sp_counter`: SP storage with masked byte load and the ±1/±2 step, parameterised by `SP_RESET` and `SP_BITS`. SREG, RAMPZ and `sp_wr_busy` stay in the top module.

## Test plan
- Reset, then idle: `spl_out`=FF, `sph_out`=08, `sreg_out`=00, `rampz_out`=00, `sp_wr_busy`=0.
- Push with step 2 from 08FF → 08FD. Pop with step 1 → 08FE. SP=0000 plus push with step 1 → 0FFF (12-bit wrap).
- I/O write 6'h3D=8'h10 in the same cycle as `sp_dec` → SP=0810 and the step is dropped. `sp_wr_busy`=1 for exactly one cycle after.
- SREG=00. `sreg_fl_we`=8'h03, `fl_in`=8'hFF, and `bset` bit 1 with `bclr` in the same cycle → SREG=03. Then `reti`+`irq_ack` together → I stays 0.
- I/O write SREG=8'hA5 in the same cycle as `irq_ack` and `sreg_fl_we`=FF → SREG=A5.
- Write 6'h3B=8'h01: with `CORE_RAMPZ_EN`, `rampz_out`=01. Without it, `rampz_out`=00 and all other registers are unchanged.

Source files
------------

// File: rtl/core_io_pkg.sv
// Shared I/O-space definitions for the core register write block and read mux.
package core_io_pkg;

    // I/O addresses of the core-internal registers
    localparam logic [5:0] P_RAMPZ_ADDRESS = 6'h3B;
    localparam logic [5:0] P_SPL_ADDRESS   = 6'h3D;
    localparam logic [5:0] P_SPH_ADDRESS   = 6'h3E;
    localparam logic [5:0] P_SREG_ADDRESS  = 6'h3F;

    // SREG bit positions
    localparam int SREG_I = 7;
    localparam int SREG_T = 6;
    localparam int SREG_H = 5;
    localparam int SREG_S = 4;
    localparam int SREG_V = 3;
    localparam int SREG_N = 2;
    localparam int SREG_Z = 1;
    localparam int SREG_C = 0;

    // Mask covering the implemented stack pointer bits
    function automatic logic [15:0] sp_mask(input int bits);
        if (bits >= 16)
            return 16'hFFFF;
        return 16'((32'd1 << bits) - 32'd1);
    endfunction

endpackage

// File: rtl/sp_counter.sv
// Stack pointer storage: byte loads from the I/O bus and +/-1, +/-2 steps.
// Bits at or above SP_BITS are held at zero.
module sp_counter
    import core_io_pkg::*;
#(
    parameter logic [15:0] SP_RESET = 16'h08FF,
    parameter int          SP_BITS  = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_lo,
    input  logic        ld_hi,
    input  logic [7:0]  din,
    input  logic        inc,
    input  logic        dec,
    input  logic        step2,
    output logic [15:0] sp
);

    localparam logic [15:0] MASK = sp_mask(SP_BITS);

    logic [15:0] sp_q;
    logic [15:0] step;
    logic [15:0] loaded;

    assign step   = step2 ? 16'd2 : 16'd1;
    assign loaded = {ld_hi ? din : sp_q[15:8], ld_lo ? din : sp_q[7:0]};
    assign sp     = sp_q;

    // Byte load beats any step; inc and dec together cancel out
    always_ff @(posedge clk) begin
        if (rst)
            sp_q <= SP_RESET & MASK;
        else if (ld_lo || ld_hi)
            sp_q <= loaded & MASK;
        else if (inc && !dec)
            sp_q <= (sp_q + step) & MASK;
        else if (dec && !inc)
            sp_q <= (sp_q - step) & MASK;
    end

endmodule

// File: rtl/io_wr_regs.sv
// Write side of the core I/O registers: SP, SREG and optional RAMPZ.
// Build option: define CORE_RAMPZ_EN to implement RAMPZ at 6'h3B.
module io_wr_regs
    import core_io_pkg::*;
#(
    parameter logic [15:0] SP_RESET = 16'h08FF,
    parameter int          SP_BITS  = 12
) (
    input  logic       cp2,
    input  logic       ireset,
    input  logic [5:0] adr,
    input  logic       iowe,
    input  logic [7:0] dbusout,
    input  logic       sp_inc,
    input  logic       sp_dec,
    input  logic       sp_step2,
    input  logic [7:0] sreg_fl_in,
    input  logic [7:0] sreg_fl_we,
    input  logic       bset,
    input  logic       bclr,
    input  logic [2:0] sreg_bit,
    input  logic       irq_ack,
    input  logic       reti,
    output logic [7:0] spl_out,
    output logic [7:0] sph_out,
    output logic [7:0] sreg_out,
    output logic [7:0] rampz_out,
    output logic       sp_wr_busy
);

    logic        wr_spl, wr_sph, wr_sreg;
    logic [15:0] sp;
    logic [7:0]  sreg_q, sreg_nxt;

    assign wr_spl  = iowe && (adr == P_SPL_ADDRESS);
    assign wr_sph  = iowe && (adr == P_SPH_ADDRESS);
    assign wr_sreg = iowe && (adr == P_SREG_ADDRESS);

    sp_counter #(
        .SP_RESET (SP_RESET),
        .SP_BITS  (SP_BITS)
    ) u_sp (
        .clk   (cp2),
        .rst   (ireset),
        .ld_lo (wr_spl),
        .ld_hi (wr_sph),
        .din   (dbusout),
        .inc   (sp_inc),
        .dec   (sp_dec),
        .step2 (sp_step2),
        .sp    (sp)
    );

    assign spl_out  = sp[7:0];
    assign sph_out  = sp[15:8];
    assign sreg_out = sreg_q;

    // SREG next value: ALU mask, then bset/bclr, reti, irq_ack, I/O write last
    always_comb begin
        sreg_nxt = (sreg_q & ~sreg_fl_we) | (sreg_fl_in & sreg_fl_we);
        if (bset)
            sreg_nxt[sreg_bit] = 1'b1;
        else if (bclr)
            sreg_nxt[sreg_bit] = 1'b0;
        if (reti)
            sreg_nxt[SREG_I] = 1'b1;
        if (irq_ack)
            sreg_nxt[SREG_I] = 1'b0;
        if (wr_sreg)
            sreg_nxt = dbusout;
    end

    // SREG register
    always_ff @(posedge cp2) begin
        if (ireset)
            sreg_q <= 8'h00;
        else
            sreg_q <= sreg_nxt;
    end

    // Hold off interrupts for one cycle after each SP byte write so a
    // back-to-back SPL/SPH pair loads atomically
    always_ff @(posedge cp2) begin
        if (ireset)
            sp_wr_busy <= 1'b0;
        else
            sp_wr_busy <= wr_spl || wr_sph;
    end

`ifdef CORE_RAMPZ_EN
    logic [7:0] rampz_q;

    // RAMPZ register, fully writable from the I/O bus
    always_ff @(posedge cp2) begin
        if (ireset)
            rampz_q <= 8'h00;
        else if (iowe && (adr == P_RAMPZ_ADDRESS))
            rampz_q <= dbusout;
    end

    assign rampz_out = rampz_q;
`else
    assign rampz_out = 8'h00;
`endif

endmodule
